// File: rtl/fullchip_out_pkg.sv
// fullchip_out_pkg
// Shared types and select encodings for the fullchip output-mux sequencer.
//   a_state_e : address arbiter states (idle / AW locked / AR locked)
//   f_state_e : frequency select states (steady / qualifying / blanking)
//   SEL_*, FREQ_SRC_*, DBG_* : values driven on the three mux select lines
package fullchip_out_pkg;

    typedef enum logic [1:0] {
        A_IDLE    = 2'd0,
        A_HOLD_AW = 2'd1,
        A_HOLD_AR = 2'd2
    } a_state_e;

    typedef enum logic [1:0] {
        F_STEADY = 2'd0,
        F_QUAL   = 2'd1,
        F_BLANK  = 2'd2
    } f_state_e;

    localparam logic SEL_AW          = 1'b0;
    localparam logic SEL_AR          = 1'b1;
    localparam logic FREQ_SRC_CLKOUT = 1'b0;
    localparam logic FREQ_SRC_ODO    = 1'b1;
    localparam logic DBG_PRIMARY     = 1'b0;
    localparam logic DBG_SECONDARY   = 1'b1;

endpackage

// File: rtl/freq_sel_qualifier.sv
// freq_sel_qualifier
// Debounces the frequency-source request and switches the freq mux select
// only after the request has held for STABLE_CYC cycles, then holds a
// BLANK_CYC-cycle blanking window during which request changes are ignored.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   freq_sel_req      : requested source (0 = clk_out_freq_out, 1 = odometer VCO)
//   freq_out_sel      : registered mux select
//   freq_switch_busy  : registered, high while qualifying or blanking
module freq_sel_qualifier
    import fullchip_out_pkg::*;
#(
    parameter int STABLE_CYC = 16,
    parameter int BLANK_CYC  = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic freq_sel_req,
    output logic freq_out_sel,
    output logic freq_switch_busy
);

    // One counter serves both the qualification and blanking phases.
    localparam int CNT_MAX = (STABLE_CYC > BLANK_CYC) ? STABLE_CYC : BLANK_CYC;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYC - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST  = CNT_W'(BLANK_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    f_state_e         f_state_r;
    f_state_e         f_state_s;
    logic [CNT_W-1:0] fcnt_r;
    logic [CNT_W-1:0] fcnt_s;
    logic             fsel_r;
    logic             fsel_s;
    logic             busy_r;

    // Next-state logic for the qualify / blank sequencer.
    always_comb begin
        f_state_s = f_state_r;
        fcnt_s    = fcnt_r;
        fsel_s    = fsel_r;
        case (f_state_r)
            F_STEADY: begin
                if (freq_sel_req != fsel_r) begin
                    f_state_s = F_QUAL;
                    fcnt_s    = CNT_ZERO;
                end else begin
                    f_state_s = F_STEADY;
                end
            end
            F_QUAL: begin
                // A request that reverts before qualifying cancels the switch.
                if (freq_sel_req == fsel_r) begin
                    f_state_s = F_STEADY;
                    fcnt_s    = CNT_ZERO;
                end else if (fcnt_r == STABLE_LAST) begin
                    fsel_s    = ~fsel_r;
                    fcnt_s    = CNT_ZERO;
                    f_state_s = F_BLANK;
                end else begin
                    fcnt_s    = fcnt_r + CNT_ONE;
                end
            end
            F_BLANK: begin
                if (fcnt_r == BLANK_LAST) begin
                    fcnt_s    = CNT_ZERO;
                    f_state_s = F_STEADY;
                end else begin
                    fcnt_s    = fcnt_r + CNT_ONE;
                end
            end
            default: begin
                f_state_s = F_STEADY;
                fcnt_s    = CNT_ZERO;
            end
        endcase
    end

    // State, counter, select and busy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            f_state_r <= F_STEADY;
            fcnt_r    <= CNT_ZERO;
            fsel_r    <= FREQ_SRC_CLKOUT;
            busy_r    <= 1'b0;
        end else begin
            f_state_r <= f_state_s;
            fcnt_r    <= fcnt_s;
            fsel_r    <= fsel_s;
            busy_r    <= (f_state_s != F_STEADY);
        end
    end

    assign freq_out_sel     = fsel_r;
    assign freq_switch_busy = busy_r;

endmodule

// File: rtl/fullchip_out_sel_ctrl.sv
// fullchip_out_sel_ctrl
// Drives the three select lines of the fullchip output mux.
//   - Address arbiter: round-robin AW/AR grant on the shared address-ready
//     pin, locked until the handshake completes or the request drops.
//   - Frequency select: delegated to freq_sel_qualifier.
//   - Debug select: static from debug_sel_cfg, or auto-alternating every
//     DBG_PERIOD cycles with a phase-start pulse.
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   awvalid, arvalid, aready     : address requests and muxed ready
//   a_write_read_sel             : registered, 0 = AW, 1 = AR
//   aw_fire, ar_fire             : combinational handshake-complete pulses
//   freq_sel_req                 : requested freq source
//   freq_out_sel, freq_switch_busy : registered freq select and busy flag
//   debug_auto, debug_sel_cfg    : debug mode and static select
//   debug_out_sel, debug_phase_start : registered debug select and pulse
module fullchip_out_sel_ctrl
    import fullchip_out_pkg::*;
#(
    parameter int FREQ_STABLE_CYC = 16,
    parameter int FREQ_BLANK_CYC  = 8,
    parameter int DBG_PERIOD      = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic awvalid,
    input  logic arvalid,
    input  logic aready,
    output logic a_write_read_sel,
    output logic aw_fire,
    output logic ar_fire,
    input  logic freq_sel_req,
    output logic freq_out_sel,
    output logic freq_switch_busy,
    input  logic debug_auto,
    input  logic debug_sel_cfg,
    output logic debug_out_sel,
    output logic debug_phase_start
);

    localparam int DCNT_W = (DBG_PERIOD > 2) ? $clog2(DBG_PERIOD) : 1;
    localparam logic [DCNT_W-1:0] DBG_LAST  = DCNT_W'(DBG_PERIOD - 1);
    localparam logic [DCNT_W-1:0] DCNT_ZERO = {DCNT_W{1'b0}};
    localparam logic [DCNT_W-1:0] DCNT_ONE  = DCNT_W'(1);

    // ------------------------------------------------------------------
    // Address arbiter
    // ------------------------------------------------------------------
    a_state_e a_state_r;
    a_state_e a_state_s;
    logic     sel_r;
    logic     sel_s;
    logic     last_grant_r;
    logic     last_grant_s;
    logic     aw_fire_s;
    logic     ar_fire_s;

    // Grant selection, lock release and fire pulses.
    always_comb begin
        a_state_s    = a_state_r;
        sel_s        = sel_r;
        last_grant_s = last_grant_r;
        aw_fire_s    = 1'b0;
        ar_fire_s    = 1'b0;
        case (a_state_r)
            A_IDLE: begin
                // On a tie, grant the side that did not complete last.
                if (awvalid && (!arvalid || (last_grant_r == SEL_AR))) begin
                    a_state_s = A_HOLD_AW;
                    sel_s     = SEL_AW;
                end else if (arvalid) begin
                    a_state_s = A_HOLD_AR;
                    sel_s     = SEL_AR;
                end else begin
                    a_state_s = A_IDLE;
                end
            end
            A_HOLD_AW: begin
                if (awvalid && aready) begin
                    // A reset in the same cycle abandons the handshake.
                    aw_fire_s    = ~rst;
                    last_grant_s = SEL_AW;
                    a_state_s    = A_IDLE;
                end else if (!awvalid) begin
                    a_state_s = A_IDLE;
                end else begin
                    a_state_s = A_HOLD_AW;
                end
            end
            A_HOLD_AR: begin
                if (arvalid && aready) begin
                    ar_fire_s    = ~rst;
                    last_grant_s = SEL_AR;
                    a_state_s    = A_IDLE;
                end else if (!arvalid) begin
                    a_state_s = A_IDLE;
                end else begin
                    a_state_s = A_HOLD_AR;
                end
            end
            default: begin
                a_state_s = A_IDLE;
            end
        endcase
    end

    // Arbiter state, select and round-robin history registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_state_r    <= A_IDLE;
            sel_r        <= SEL_AW;
            last_grant_r <= SEL_AR;
        end else begin
            a_state_r    <= a_state_s;
            sel_r        <= sel_s;
            last_grant_r <= last_grant_s;
        end
    end

    assign a_write_read_sel = sel_r;
    assign aw_fire          = aw_fire_s;
    assign ar_fire          = ar_fire_s;

    // ------------------------------------------------------------------
    // Frequency select
    // ------------------------------------------------------------------
    freq_sel_qualifier #(
        .STABLE_CYC (FREQ_STABLE_CYC),
        .BLANK_CYC  (FREQ_BLANK_CYC)
    ) u_freq_sel_qualifier (
        .clk              (clk),
        .rst              (rst),
        .freq_sel_req     (freq_sel_req),
        .freq_out_sel     (freq_out_sel),
        .freq_switch_busy (freq_switch_busy)
    );

    // ------------------------------------------------------------------
    // Debug select
    // ------------------------------------------------------------------
    logic [DCNT_W-1:0] dcnt_r;
    logic              dsel_r;
    logic              dpulse_r;
    logic              auto_prev_r;

    // Static select, auto-mode entry, and periodic phase alternation.
    always_ff @(posedge clk) begin
        if (rst) begin
            dcnt_r      <= DCNT_ZERO;
            dsel_r      <= DBG_PRIMARY;
            dpulse_r    <= 1'b0;
            auto_prev_r <= 1'b0;
        end else begin
            auto_prev_r <= debug_auto;
            if (!debug_auto) begin
                dcnt_r   <= DCNT_ZERO;
                dsel_r   <= debug_sel_cfg;
                dpulse_r <= 1'b0;
            end else if (!auto_prev_r) begin
                // Entering auto mode always starts on the primary output.
                dcnt_r   <= DCNT_ZERO;
                dsel_r   <= DBG_PRIMARY;
                dpulse_r <= 1'b1;
            end else if (dcnt_r == DBG_LAST) begin
                dcnt_r   <= DCNT_ZERO;
                dsel_r   <= ~dsel_r;
                dpulse_r <= 1'b1;
            end else begin
                dcnt_r   <= dcnt_r + DCNT_ONE;
                dpulse_r <= 1'b0;
            end
        end
    end

    assign debug_out_sel     = dsel_r;
    assign debug_phase_start = dpulse_r;

endmodule

// File: tb/tb_fullchip_out_sel_ctrl.sv
// Self-checking bench for fullchip_out_sel_ctrl: directed scenarios plus
// randomized traffic, all compared against a behavioural model.
module tb_fullchip_out_sel_ctrl;

    localparam int S = 16;
    localparam int B = 8;
    localparam int P = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, awvalid, arvalid, aready, freq_sel_req, debug_auto, debug_sel_cfg;
    logic a_write_read_sel, aw_fire, ar_fire, freq_out_sel, freq_switch_busy;
    logic debug_out_sel, debug_phase_start;

    fullchip_out_sel_ctrl #(
        .FREQ_STABLE_CYC (S),
        .FREQ_BLANK_CYC  (B),
        .DBG_PERIOD      (P)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .awvalid           (awvalid),
        .arvalid           (arvalid),
        .aready            (aready),
        .a_write_read_sel  (a_write_read_sel),
        .aw_fire           (aw_fire),
        .ar_fire           (ar_fire),
        .freq_sel_req      (freq_sel_req),
        .freq_out_sel      (freq_out_sel),
        .freq_switch_busy  (freq_switch_busy),
        .debug_auto        (debug_auto),
        .debug_sel_cfg     (debug_sel_cfg),
        .debug_out_sel     (debug_out_sel),
        .debug_phase_start (debug_phase_start)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Behavioural model: who owns the address pin, how long a request has
    // been pending, how much blanking remains, cycles elapsed in auto mode.
    int   m_owner;      // 0 none, 1 AW, 2 AR
    logic m_sel;
    int   m_last;       // 0 AW finished last, 1 AR finished last
    logic m_fout;
    bit   m_qual;
    int   m_qlen;
    int   m_blank;
    logic m_dsel, m_dpulse;
    bit   m_prev_auto;
    int   m_dcyc;

    logic obs_sel, obs_awf, obs_arf, obs_fsel, obs_busy, obs_dsel, obs_dpulse;

    task automatic model_reset();
        m_owner = 0; m_sel = 1'b0; m_last = 1;
        m_fout = 1'b0; m_qual = 1'b0; m_qlen = 0; m_blank = 0;
        m_dsel = 1'b0; m_dpulse = 1'b0; m_prev_auto = 1'b0; m_dcyc = 0;
    endtask

    // Called at a falling edge with this cycle's inputs applied; checks
    // the cycle, advances the model across the rising edge, returns at the
    // next falling edge.
    task automatic tick();
        logic e_awf, e_arf;
        #1;
        e_awf = (m_owner == 1) && awvalid && aready && !rst;
        e_arf = (m_owner == 2) && arvalid && aready && !rst;
        obs_sel = a_write_read_sel; obs_awf = aw_fire; obs_arf = ar_fire;
        obs_fsel = freq_out_sel; obs_busy = freq_switch_busy;
        obs_dsel = debug_out_sel; obs_dpulse = debug_phase_start;
        check_eq("a_write_read_sel", obs_sel, m_sel);
        check_eq("aw_fire", obs_awf, e_awf);
        check_eq("ar_fire", obs_arf, e_arf);
        check_eq("freq_out_sel", obs_fsel, m_fout);
        check_eq("freq_switch_busy", obs_busy, m_qual || (m_blank > 0));
        check_eq("debug_out_sel", obs_dsel, m_dsel);
        check_eq("debug_phase_start", obs_dpulse, m_dpulse);
        if (rst) begin
            model_reset();
        end else begin
            // arbiter
            if (m_owner == 0) begin
                if (awvalid && (!arvalid || m_last == 1)) begin m_owner = 1; m_sel = 1'b0; end
                else if (arvalid) begin m_owner = 2; m_sel = 1'b1; end
            end else if (m_owner == 1) begin
                if (e_awf) m_last = 0;
                if (e_awf || !awvalid) m_owner = 0;
            end else begin
                if (e_arf) m_last = 1;
                if (e_arf || !arvalid) m_owner = 0;
            end
            // frequency
            if (m_blank > 0) begin
                m_blank--;
            end else if (m_qual) begin
                if (freq_sel_req == m_fout) m_qual = 1'b0;
                else begin
                    m_qlen++;
                    if (m_qlen == S) begin m_fout = ~m_fout; m_qual = 1'b0; m_blank = B; end
                end
            end else if (freq_sel_req != m_fout) begin
                m_qual = 1'b1; m_qlen = 0;
            end
            // debug
            if (!debug_auto) begin
                m_dsel = debug_sel_cfg; m_dpulse = 1'b0;
            end else if (!m_prev_auto) begin
                m_dcyc = 0; m_dsel = 1'b0; m_dpulse = 1'b1;
            end else begin
                m_dcyc++;
                m_dsel = ((m_dcyc / P) % 2) == 1;
                m_dpulse = (m_dcyc % P) == 0;
            end
            m_prev_auto = debug_auto;
        end
        @(negedge clk);
    endtask

    int cnt, first;

    initial begin
        rst = 1'b1; awvalid = 1'b0; arvalid = 1'b0; aready = 1'b0;
        freq_sel_req = 1'b0; debug_auto = 1'b0; debug_sel_cfg = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();
        #1;
        check_eq("reset_sel", a_write_read_sel, 1'b0);
        check_eq("reset_fsel", freq_out_sel, 1'b0);
        check_eq("reset_busy", freq_switch_busy, 1'b0);
        check_eq("reset_dpulse", debug_phase_start, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Tie after reset: AW first, then AR after the AW handshake.
        awvalid = 1'b1; arvalid = 1'b1; tick();
        tick();                       check_eq("tie_aw_first", obs_sel, 1'b0);
        aready = 1'b1; tick();        check_eq("tie_aw_fire", obs_awf, 1'b1);
        aready = 1'b0; tick(); tick(); check_eq("then_ar", obs_sel, 1'b1);
        awvalid = 1'b0; arvalid = 1'b0; tick(); tick();

        // AW held off by missing ready, AR waiting, then AW withdraws.
        awvalid = 1'b1; tick();
        arvalid = 1'b1;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin tick(); if (obs_sel || obs_awf || obs_arf) cnt++; end
        check_eq("hold_aw_stable", cnt, 0);
        awvalid = 1'b0; tick();       check_eq("drop_no_fire", obs_awf, 1'b0);
        tick(); tick();               check_eq("ar_after_drop", obs_sel, 1'b1);
        arvalid = 1'b0; tick();

        // Frequency switch 0 -> 1 with full qualification and blanking.
        freq_sel_req = 1'b1; cnt = 0; first = -1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (obs_busy) cnt++;
            if (obs_fsel && first < 0) first = i;
        end
        check_eq("freq_switch_at", first, S + 1);
        check_eq("freq_busy_len", cnt, S + B);
        // Short request pulse: no switch.
        freq_sel_req = 1'b0; cnt = 0; first = 0;
        for (int i = 0; i < 30; i++) begin
            if (i == 10) freq_sel_req = 1'b1;
            tick();
            if (obs_busy) cnt++;
            if (!obs_fsel) first++;
        end
        check_eq("pulse_busy_len", cnt, 10);
        check_eq("pulse_no_switch", first, 0);
        // Request reverted during blanking is re-qualified afterwards.
        freq_sel_req = 1'b0;
        for (int i = 0; i < 70; i++) begin
            if (i == 20) freq_sel_req = 1'b1;
            tick();
        end
        check_eq("blank_requal_final", obs_fsel, 1'b1);

        // Debug auto alternation, then static select.
        debug_auto = 1'b1; cnt = 0;
        for (int i = 0; i < 200; i++) begin tick(); if (obs_dpulse) cnt++; end
        check_eq("dbg_auto_pulses", cnt, 4);
        debug_auto = 1'b0; debug_sel_cfg = 1'b1; tick();
        cnt = 0;
        for (int i = 0; i < 10; i++) begin tick(); if (obs_dpulse) cnt++; end
        check_eq("dbg_static_sel", obs_dsel, 1'b1);
        check_eq("dbg_static_pulses", cnt, 0);

        // Reset during AR hold and freq qualification.
        arvalid = 1'b1; freq_sel_req = ~freq_out_sel; tick(); tick();
        rst = 1'b1; aready = 1'b1; tick();
        check_eq("rst_no_ar_fire", obs_arf, 1'b0);
        rst = 1'b0; aready = 1'b0; arvalid = 1'b0; freq_sel_req = 1'b0; tick();
        check_eq("post_rst_sel", obs_sel, 1'b0);
        check_eq("post_rst_fsel", obs_fsel, 1'b0);
        check_eq("post_rst_busy", obs_busy, 1'b0);
        check_eq("post_rst_dsel", obs_dsel, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            awvalid = ($urandom_range(0, 1) == 1);
            arvalid = ($urandom_range(0, 1) == 1);
            aready  = ($urandom_range(0, 9) < 4);
            if ($urandom_range(0, 39) == 0) freq_sel_req = ~freq_sel_req;
            if ($urandom_range(0, 299) == 0) debug_auto = ~debug_auto;
            debug_sel_cfg = ($urandom_range(0, 1) == 1);
            rst = ($urandom_range(0, 499) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
